// File: rtl/pll_lock_reset_pkg.sv
// Shared types and constants for the PLL lock / reset sequencer.
package pll_lock_reset_pkg;

  typedef enum logic [2:0] {
    StWaitLock  = 3'd0,
    StStabilise = 3'd1,
    StFabricUp  = 3'd2,
    StRun       = 3'd3,
    StSoftRst   = 3'd4
  } state_e;

  localparam int unsigned LOSS_CNT_W = 8;
  localparam logic [LOSS_CNT_W-1:0] LOSS_CNT_MAX = 8'd255;

endpackage

// File: rtl/bit_sync.sv
// Single-bit multi-flop synchroniser with synchronous active-high reset; output 0 in reset.
module bit_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RESET,
  input  logic data_i,
  output logic sync_o
);

  if (SYNC_STAGES < 2) begin : g_bad_stages
    $error("bit_sync: SYNC_STAGES must be >= 2");
  end

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], data_i};
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_reset_sequencer.sv
// Filters the CCC LOCK flag and sequences fabric and core resets, with core-only soft reset.
module pll_lock_reset_sequencer
  import pll_lock_reset_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned CORE_DELAY    = 64,
  parameter int unsigned SOFT_CYCLES   = 16,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  LOCK,
  input  logic                  SOFT_RESET_REQ,
  output logic                  FABRIC_RESET_N,
  output logic                  CORE_RESET_N,
  output logic                  PLL_READY,
  output logic [LOSS_CNT_W-1:0] LOCK_LOSS_COUNT
);

  localparam int unsigned MaxA = (STABLE_CYCLES > CORE_DELAY) ? STABLE_CYCLES : CORE_DELAY;
  localparam int unsigned MaxCycles = (MaxA > SOFT_CYCLES) ? MaxA : SOFT_CYCLES;
  localparam bit CntTooSmall = (CNT_W == 0) ||
                               ((CNT_W < 32) && (64'(MaxCycles) > ((64'd1 << CNT_W) - 64'd1)));

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("pll_lock_reset_sequencer: SYNC_STAGES must be >= 2");
  end
  if (STABLE_CYCLES < 1 || CORE_DELAY < 1 || SOFT_CYCLES < 1) begin : g_bad_cycles
    $error("pll_lock_reset_sequencer: cycle parameters must be >= 1");
  end
  if (CntTooSmall) begin : g_bad_cnt
    $error("pll_lock_reset_sequencer: CNT_W too small for the cycle parameters");
  end

  localparam logic [CNT_W-1:0] StableLast = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CoreLast   = CNT_W'(CORE_DELAY - 1);
  localparam logic [CNT_W-1:0] SoftLast   = CNT_W'(SOFT_CYCLES - 1);

  logic                  lock_s;
  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  lock_lost;
  logic                  fabric_rst_n_q, fabric_rst_n_d;
  logic                  core_rst_n_q, core_rst_n_d;
  logic                  ready_q, ready_d;
  logic [LOSS_CNT_W-1:0] loss_q, loss_d;

  bit_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .CLK    (CLK),
    .RESET  (RESET),
    .data_i (LOCK),
    .sync_o (lock_s)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= StWaitLock;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Lock loss outranks everything once the fabric is up, including a soft request.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lock_lost = 1'b0;
    unique case (state_q)
      StWaitLock: begin
        if (lock_s) begin
          state_d = StStabilise;
          cnt_d   = '0;
        end
      end
      StStabilise: begin
        if (!lock_s) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else if (cnt_q == StableLast) begin
          state_d = StFabricUp;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StFabricUp: begin
        if (!lock_s) begin
          state_d   = StWaitLock;
          cnt_d     = '0;
          lock_lost = 1'b1;
        end else if (cnt_q == CoreLast) begin
          state_d = StRun;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StRun: begin
        if (!lock_s) begin
          state_d   = StWaitLock;
          cnt_d     = '0;
          lock_lost = 1'b1;
        end else if (SOFT_RESET_REQ) begin
          state_d = StSoftRst;
          cnt_d   = '0;
        end
      end
      StSoftRst: begin
        if (!lock_s) begin
          state_d   = StWaitLock;
          cnt_d     = '0;
          lock_lost = 1'b1;
        end else if (cnt_q == SoftLast) begin
          state_d = StRun;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = StWaitLock;
        cnt_d   = '0;
      end
    endcase
  end

  // Output registers are loaded from the next state so every output is a plain flop.
  always_comb begin
    fabric_rst_n_d = (state_d == StFabricUp) || (state_d == StRun) || (state_d == StSoftRst);
    core_rst_n_d   = (state_d == StRun);
    ready_d        = fabric_rst_n_d;
    loss_d         = loss_q;
    if (lock_lost && (loss_q != LOSS_CNT_MAX)) begin
      loss_d = loss_q + 8'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      fabric_rst_n_q <= 1'b0;
      core_rst_n_q   <= 1'b0;
      ready_q        <= 1'b0;
      loss_q         <= '0;
    end else begin
      fabric_rst_n_q <= fabric_rst_n_d;
      core_rst_n_q   <= core_rst_n_d;
      ready_q        <= ready_d;
      loss_q         <= loss_d;
    end
  end

  assign FABRIC_RESET_N  = fabric_rst_n_q;
  assign CORE_RESET_N    = core_rst_n_q;
  assign PLL_READY       = ready_q;
  assign LOCK_LOSS_COUNT = loss_q;

endmodule

// File: tb/tb_pll_lock_reset_sequencer.sv
// Randomised self-checking bench for pll_lock_reset_sequencer against a lock-streak model.
module tb_pll_lock_reset_sequencer;

  localparam int TbSync   = 2;
  localparam int TbStable = 8;
  localparam int TbCore   = 4;
  localparam int TbSoft   = 3;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       LOCK = 1'b0;
  logic       SOFT_RESET_REQ = 1'b0;
  logic       FABRIC_RESET_N;
  logic       CORE_RESET_N;
  logic       PLL_READY;
  logic [7:0] LOCK_LOSS_COUNT;

  int checks = 0;
  int errors = 0;

  // Model: outputs follow from how many consecutive edges the synchronised lock has been high.
  bit         m_sync [TbSync];
  int         m_h = 0;
  int         m_edge = 0;
  int         m_soft_until = 0;
  logic [7:0] m_loss = 8'd0;
  bit         m_fab = 1'b0;
  bit         m_core = 1'b0;

  wire [10:0] dut_vec = {FABRIC_RESET_N, CORE_RESET_N, PLL_READY, LOCK_LOSS_COUNT};

  pll_lock_reset_sequencer #(
    .SYNC_STAGES   (TbSync),
    .STABLE_CYCLES (TbStable),
    .CORE_DELAY    (TbCore),
    .SOFT_CYCLES   (TbSoft),
    .CNT_W         (16)
  ) dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .LOCK            (LOCK),
    .SOFT_RESET_REQ  (SOFT_RESET_REQ),
    .FABRIC_RESET_N  (FABRIC_RESET_N),
    .CORE_RESET_N    (CORE_RESET_N),
    .PLL_READY       (PLL_READY),
    .LOCK_LOSS_COUNT (LOCK_LOSS_COUNT)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (CORE_RESET_N === 1'b1 && FABRIC_RESET_N !== 1'b1) begin
      errors++;
      $display("FAIL core_before_fabric t=%0t core=%b fabric=%b", $time, CORE_RESET_N,
               FABRIC_RESET_N);
    end
  end

  function automatic logic [10:0] exp_vec();
    return {m_fab, m_core, m_fab, m_loss};
  endfunction

  task automatic tick();
    bit lock_s_pre;
    m_edge++;
    if (RESET) begin
      for (int i = 0; i < TbSync; i++) m_sync[i] = 1'b0;
      m_h = 0;
      m_loss = 8'd0;
      m_soft_until = 0;
      m_fab = 1'b0;
      m_core = 1'b0;
    end else begin
      lock_s_pre = m_sync[TbSync-1];
      if (!lock_s_pre) begin
        if (m_fab && m_loss != 8'd255) m_loss = m_loss + 8'd1;
        m_h = 0;
        m_soft_until = 0;
      end else begin
        if (m_h < 1000000) m_h++;
        if (m_core && SOFT_RESET_REQ) m_soft_until = m_edge + TbSoft;
      end
      for (int i = TbSync - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
      m_sync[0] = LOCK;
      m_fab  = (m_h >= TbStable + 1);
      m_core = m_fab && (m_h >= TbStable + 1 + TbCore) && (m_edge >= m_soft_until);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    LOCK = 1'b0;
    SOFT_RESET_REQ = 1'b0;
    repeat (2) tick();
    RESET = 1'b0;
  endtask

  task automatic bring_to_run();
    do_reset();
    LOCK = 1'b1;
    repeat (16) tick();
  endtask

  task automatic test_reset();
    int fab_edge = 0;
    int core_edge = 0;
    RESET = 1'b1;
    LOCK = 1'b0;
    SOFT_RESET_REQ = 1'b0;
    repeat (5) tick();
    checks++;
    if (dut_vec !== 11'd0) begin
      errors++;
      $display("FAIL reset_state got=%h exp=%h", dut_vec, 11'd0);
    end
    RESET = 1'b0;
    LOCK = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL reset_seq k=%0d got=%h exp=%h", k, dut_vec, exp_vec());
      end
      if (FABRIC_RESET_N === 1'b1 && fab_edge == 0) fab_edge = k;
      if (CORE_RESET_N === 1'b1 && core_edge == 0) core_edge = k;
    end
    checks++;
    if (fab_edge != 11) begin
      errors++;
      $display("FAIL fabric_release_edge got=%0d exp=11", fab_edge);
    end
    checks++;
    if (core_edge != 15) begin
      errors++;
      $display("FAIL core_release_edge got=%0d exp=15", core_edge);
    end
  endtask

  task automatic test_glitch();
    int fab_edge = 0;
    do_reset();
    LOCK = 1'b1;
    repeat (6) tick();
    LOCK = 1'b0;
    tick();
    LOCK = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL glitch_seq k=%0d got=%h exp=%h", k, dut_vec, exp_vec());
      end
      if (FABRIC_RESET_N === 1'b1 && fab_edge == 0) fab_edge = k;
    end
    checks++;
    if (fab_edge != 11 || LOCK_LOSS_COUNT !== 8'd0) begin
      errors++;
      $display("FAIL glitch_restart got edge=%0d loss=%0d exp edge=11 loss=0", fab_edge,
               LOCK_LOSS_COUNT);
    end
  endtask

  task automatic test_lock_loss();
    int fab_edge = 0;
    bring_to_run();
    LOCK = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL loss_seq k=%0d got=%h exp=%h", k, dut_vec, exp_vec());
      end
      if (k == 2) begin
        checks++;
        if (FABRIC_RESET_N !== 1'b1) begin
          errors++;
          $display("FAIL loss_early got fabric=%b exp=1", FABRIC_RESET_N);
        end
      end
    end
    checks++;
    if (dut_vec !== {3'b000, 8'd1}) begin
      errors++;
      $display("FAIL loss_third_edge got=%h exp=%h", dut_vec, {3'b000, 8'd1});
    end
    LOCK = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL loss_reseq k=%0d got=%h exp=%h", k, dut_vec, exp_vec());
      end
      if (FABRIC_RESET_N === 1'b1 && fab_edge == 0) fab_edge = k;
    end
    checks++;
    if (fab_edge != 11) begin
      errors++;
      $display("FAIL loss_reseq_edge got=%0d exp=11", fab_edge);
    end
  endtask

  task automatic test_soft_reset();
    int low_cnt = 0;
    int fab_low = 0;
    bring_to_run();
    for (int k = 0; k < 10; k++) begin
      SOFT_RESET_REQ = (k == 0 || k == 2);
      tick();
      if (CORE_RESET_N !== 1'b1) low_cnt++;
      if (FABRIC_RESET_N !== 1'b1) fab_low++;
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL soft_seq k=%0d got=%h exp=%h", k, dut_vec, exp_vec());
      end
    end
    SOFT_RESET_REQ = 1'b0;
    checks++;
    if (low_cnt != TbSoft || fab_low != 0) begin
      errors++;
      $display("FAIL soft_window got low=%0d fablow=%0d exp low=3 fablow=0", low_cnt, fab_low);
    end
    for (int k = 0; k < 80; k++) begin
      SOFT_RESET_REQ = ($urandom_range(0, 5) == 0);
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL soft_rand k=%0d got=%h exp=%h", k, dut_vec, exp_vec());
      end
    end
    SOFT_RESET_REQ = 1'b0;
  endtask

  task automatic test_loss_vs_soft();
    int hi;
    int lo;
    bring_to_run();
    LOCK = 1'b0;
    repeat (2) tick();
    SOFT_RESET_REQ = 1'b1;
    tick();
    SOFT_RESET_REQ = 1'b0;
    checks++;
    if (dut_vec !== {3'b000, 8'd1}) begin
      errors++;
      $display("FAIL loss_beats_soft got=%h exp=%h", dut_vec, {3'b000, 8'd1});
    end
    for (int n = 0; n < 300; n++) begin
      hi = 12 + $urandom_range(0, 4);
      lo = 3 + $urandom_range(0, 2);
      LOCK = 1'b1;
      for (int k = 0; k < hi + lo; k++) begin
        if (k == hi) LOCK = 1'b0;
        SOFT_RESET_REQ = ($urandom_range(0, 7) == 0);
        tick();
        checks++;
        if (dut_vec !== exp_vec()) begin
          errors++;
          $display("FAIL sat_seq n=%0d k=%0d got=%h exp=%h", n, k, dut_vec, exp_vec());
        end
      end
    end
    SOFT_RESET_REQ = 1'b0;
    checks++;
    if (LOCK_LOSS_COUNT !== 8'd255) begin
      errors++;
      $display("FAIL loss_saturate got=%0d exp=255", LOCK_LOSS_COUNT);
    end
  endtask

  task automatic test_reset_mid();
    int fab_edge;
    bring_to_run();
    LOCK = 1'b0;
    repeat (3) tick();
    LOCK = 1'b1;
    repeat (16) tick();
    checks++;
    if (dut_vec !== {3'b111, 8'd1}) begin
      errors++;
      $display("FAIL mid_run_pre got=%h exp=%h", dut_vec, {3'b111, 8'd1});
    end
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) begin
        SOFT_RESET_REQ = 1'b1;
        tick();
        SOFT_RESET_REQ = 1'b0;
        checks++;
        if (CORE_RESET_N !== 1'b0 || FABRIC_RESET_N !== 1'b1) begin
          errors++;
          $display("FAIL mid_soft_pre got core=%b fabric=%b exp core=0 fabric=1",
                   CORE_RESET_N, FABRIC_RESET_N);
        end
      end
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
      checks++;
      if (dut_vec !== 11'd0) begin
        errors++;
        $display("FAIL mid_reset pass=%0d got=%h exp=%h", pass, dut_vec, 11'd0);
      end
      fab_edge = 0;
      for (int k = 1; k <= 16; k++) begin
        tick();
        checks++;
        if (dut_vec !== exp_vec()) begin
          errors++;
          $display("FAIL mid_reseq pass=%0d k=%0d got=%h exp=%h", pass, k, dut_vec, exp_vec());
        end
        if (FABRIC_RESET_N === 1'b1 && fab_edge == 0) fab_edge = k;
      end
      checks++;
      if (fab_edge != 11) begin
        errors++;
        $display("FAIL mid_reseq_edge pass=%0d got=%0d exp=11", pass, fab_edge);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 24) == 0) LOCK = ~LOCK;
      SOFT_RESET_REQ = ($urandom_range(0, 7) == 0);
      RESET = ($urandom_range(0, 199) == 0);
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL random k=%0d got=%h exp=%h", k, dut_vec, exp_vec());
      end
    end
    RESET = 1'b0;
    SOFT_RESET_REQ = 1'b0;
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_lock_loss();
    test_soft_reset();
    test_loss_vs_soft();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
